// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit sequencer.
//   - FSM state encodings (legacy-style localparam constants)
//   - STUFF_LIMIT: the number of consecutive 1s after which a 0 is stuffed
//   - SYNC_DEFAULT: the default SYNC byte, sent LSB first
package usb_tx_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STUFF = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int         STUFF_LIMIT  = 6;
  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

endpackage

// File: rtl/usb_tx_if.sv
// Byte-stream-in / serial-out bundle for the USB transmit sequencer.
//   slave  : the sequencer (takes bytes, drives serial and status)
//   master : the packet source plus the serial consumer
interface usb_tx_if;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_last;
  logic       tx_byte_ready;
  logic       tx_serial_data;
  logic       tx_data_valid;
  logic       tx_busy;
  logic       tx_underrun;

  modport slave (
    input  tx_start, tx_byte, tx_byte_valid, tx_last,
    output tx_byte_ready, tx_serial_data, tx_data_valid, tx_busy, tx_underrun
  );

  modport master (
    output tx_start, tx_byte, tx_byte_valid, tx_last,
    input  tx_byte_ready, tx_serial_data, tx_data_valid, tx_busy, tx_underrun
  );
endinterface

// File: rtl/usb_bit_stuff.sv
// Bit-stuffing tracker.
//   gclk, reset_l : clock, async active-low reset
//   clr           : clears the run of ones (packet start)
//   emit          : a bit is on the wire this cycle
//   bit_in        : the bit on the wire
//   stuff_next    : this bit completes a run of STUFF_LIMIT ones, so the
//                   next cycle must carry a stuffed 0
module usb_bit_stuff
  import usb_tx_pkg::*;
(
  input  logic gclk,
  input  logic reset_l,
  input  logic clr,
  input  logic emit,
  input  logic bit_in,
  output logic stuff_next
);

  logic [2:0] ones_cnt;

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l)         ones_cnt <= 3'd0;
    else if (clr)         ones_cnt <= 3'd0;
    else if (emit)        ones_cnt <= bit_in ? ones_cnt + 3'd1 : 3'd0;
  end

  // Look at the count before this bit: it is the sixth 1 if count is 5.
  assign stuff_next = emit && bit_in && (ones_cnt == 3'(STUFF_LIMIT - 1));

endmodule

// File: rtl/usb_tx_seq.sv
// USB 2.0 transmit sequencer: SYNC, LSB-first byte serialization, bit
// stuffing, EOP trigger (tx_data_valid fall) and inter-packet gap.
//   gclk, reset_l : one bit time per clock, async active-low reset
//   bus (slave)   : tx_start/tx_byte/tx_byte_valid/tx_last in,
//                   tx_byte_ready/tx_serial_data/tx_data_valid/
//                   tx_busy/tx_underrun out
// The state register always describes the bit currently on the wire;
// tx_serial_data/tx_data_valid/tx_busy/tx_underrun are flops, and
// tx_byte_ready is a decode of flops only.
module usb_tx_seq
  import usb_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = SYNC_DEFAULT,
  parameter int         GAP_CYCLES   = 2
) (
  input  logic     gclk,
  input  logic     reset_l,
  usb_tx_if.slave  bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [2:0]    state, state_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          last_r, last_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          ser_q, ser_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          und_q, und_d;
  logic          stuff_next;
  logic          start_acc;
  logic          byte_end;

  assign start_acc = (state == S_IDLE) && bus.tx_start;

  usb_bit_stuff u_stuff (
    .gclk       (gclk),
    .reset_l    (reset_l),
    .clr        (start_acc),
    .emit       (vld_q),
    .bit_in     (ser_q),
    .stuff_next (stuff_next)
  );

  // Ready in the last cycle before the next byte's bit 0 would go out:
  // last SYNC bit, bit 7 with no stuff pending, or the stuff after bit 7.
  always_comb begin
    bus.tx_byte_ready = 1'b0;
    if (bit_cnt == 3'd7) begin
      if (state == S_SYNC)
        bus.tx_byte_ready = 1'b1;
      else if (!last_r && ((state == S_DATA && !stuff_next) || state == S_STUFF))
        bus.tx_byte_ready = 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    last_d    = last_r;
    gap_d     = gap_cnt;
    ser_d     = ser_q;
    vld_d     = vld_q;
    busy_d    = busy_q;
    und_d     = 1'b0;
    byte_end  = 1'b0;
    case (state)
      S_IDLE: if (bus.tx_start) begin
        state_d   = S_SYNC;
        bit_cnt_d = 3'd0;
        ser_d     = SYNC_PATTERN[0];
        vld_d     = 1'b1;
        busy_d    = 1'b1;
        last_d    = 1'b0;
      end
      S_SYNC: begin
        if (bit_cnt != 3'd7) begin
          bit_cnt_d = bit_cnt + 3'd1;
          ser_d     = SYNC_PATTERN[bit_cnt + 3'd1];
        end else byte_end = 1'b1;
      end
      S_DATA: begin
        if (stuff_next) begin
          // shift register and bit_cnt hold across the stuffed 0
          state_d = S_STUFF;
          ser_d   = 1'b0;
        end else if (bit_cnt != 3'd7) begin
          bit_cnt_d = bit_cnt + 3'd1;
          shreg_d   = shreg >> 1;
          ser_d     = shreg[1];
        end else byte_end = 1'b1;
      end
      S_STUFF: begin
        if (bit_cnt != 3'd7) begin
          state_d   = S_DATA;
          bit_cnt_d = bit_cnt + 3'd1;
          shreg_d   = shreg >> 1;
          ser_d     = shreg[1];
        end else byte_end = 1'b1;
      end
      S_ABORT: begin
        state_d = S_GAP;
        vld_d   = 1'b0;
        ser_d   = 1'b0;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else gap_d = gap_cnt + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        ser_d   = 1'b0;
      end
    endcase
    // Byte boundary: either finish the packet, load the next byte, or abort.
    if (byte_end) begin
      if (last_r) begin
        state_d = S_GAP;
        vld_d   = 1'b0;
        ser_d   = 1'b0;
        gap_d   = '0;
      end else if (bus.tx_byte_valid) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
        shreg_d   = bus.tx_byte;
        ser_d     = bus.tx_byte[0];
        last_d    = bus.tx_last;
      end else begin
        // valid stays high one more cycle, then the fall makes the EOP
        state_d = S_ABORT;
        ser_d   = 1'b0;
        und_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= S_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      last_r  <= 1'b0;
      gap_cnt <= '0;
      ser_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      last_r  <= last_d;
      gap_cnt <= gap_d;
      ser_q   <= ser_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      und_q   <= und_d;
    end
  end

  assign bus.tx_serial_data = ser_q;
  assign bus.tx_data_valid  = vld_q;
  assign bus.tx_busy        = busy_q;
  assign bus.tx_underrun    = und_q;

endmodule

// File: tb/tb_usb_tx_seq.sv
module tb_usb_tx_seq;

  logic gclk = 1'b0;
  logic reset_l;
  int   checks = 0;
  int   errors = 0;

  usb_tx_if bus ();

  usb_tx_seq #(.SYNC_PATTERN(8'h80), .GAP_CYCLES(2)) dut (
    .gclk    (gclk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 gclk = ~gclk;

  logic       s_log [0:63];
  logic       v_log [0:63];
  logic       r_log [0:63];
  logic       u_log [0:63];
  logic       b_log [0:63];
  logic [7:0] bq    [0:3];
  int         n_valid, max_ones;

  // Drives one packet from cycle 0 (caller is just after a posedge) and
  // logs outputs at each negedge. nsup < nb leaves later bytes unsupplied.
  task automatic run_pkt(input int nb, input bit mark_last, input int nsup,
                         input int pulse_cyc, input int ncyc);
    int idx = 0;
    int run1 = 0;
    n_valid = 0;
    max_ones = 0;
    for (int c = 0; c < ncyc; c++) begin
      bus.tx_start      = (c == 0) || (c == pulse_cyc);
      bus.tx_byte       = bq[idx & 3];
      bus.tx_byte_valid = (idx < nsup);
      bus.tx_last       = mark_last && (idx == nb - 1);
      @(negedge gclk);
      s_log[c] = bus.tx_serial_data;
      v_log[c] = bus.tx_data_valid;
      r_log[c] = bus.tx_byte_ready;
      u_log[c] = bus.tx_underrun;
      b_log[c] = bus.tx_busy;
      if (v_log[c]) begin
        n_valid++;
        run1 = s_log[c] ? run1 + 1 : 0;
        if (run1 > max_ones) max_ones = run1;
      end
      if (r_log[c] && bus.tx_byte_valid) idx++;
      @(posedge gclk);
      #1;
    end
    bus.tx_start      = 1'b0;
    bus.tx_byte_valid = 1'b0;
    bus.tx_last       = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge gclk);
    checks++; if (bus.tx_serial_data !== 1'b0) begin errors++; $display("FAIL rst_serial got %b want 0", bus.tx_serial_data); end
    checks++; if (bus.tx_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.tx_data_valid); end
    checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.tx_busy); end
    checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b want 0", bus.tx_underrun); end
    checks++; if (bus.tx_byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.tx_byte_ready); end
    @(posedge gclk); #1;
    reset_l = 1'b1;
    @(posedge gclk); #1;
  endtask

  task automatic test_single();
    logic [0:15] exp = 16'b00000001_01001011;
    int nr = 0;
    bq[0] = 8'hD2;
    run_pkt(1, 1'b1, 1, -1, 24);
    checks++; if (v_log[0] !== 1'b0) begin errors++; $display("FAIL single_v0 got %b want 0", v_log[0]); end
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (s_log[c] !== exp[c-1] || v_log[c] !== 1'b1) begin
        errors++; $display("FAIL single_bit c=%0d got s=%b v=%b want s=%b v=1", c, s_log[c], v_log[c], exp[c-1]);
      end
    end
    for (int c = 0; c < 24; c++) if (r_log[c]) nr++;
    checks++; if (r_log[8] !== 1'b1 || nr != 1) begin errors++; $display("FAIL single_ready r8=%b count=%0d want 1/1", r_log[8], nr); end
    checks++; if (v_log[17] !== 1'b0) begin errors++; $display("FAIL single_vfall got %b want 0", v_log[17]); end
    checks++; if (b_log[1] !== 1'b1 || b_log[18] !== 1'b1) begin errors++; $display("FAIL single_busy b1=%b b18=%b want 1", b_log[1], b_log[18]); end
    checks++; if (b_log[19] !== 1'b0) begin errors++; $display("FAIL single_busyfall got %b want 0", b_log[19]); end
    checks++; if (n_valid != 16) begin errors++; $display("FAIL single_len got %0d want 16", n_valid); end
  endtask

  task automatic test_stuff_ff();
    // SYNC, 5 ones, stuff, 3 ones | byte1: 3 ones, stuff, 5 ones
    logic [0:25] exp = 26'b00000001_11111_0_111_111_0_11111;
    bq[0] = 8'hFF; bq[1] = 8'hFF;
    run_pkt(2, 1'b1, 2, -1, 34);
    for (int c = 1; c <= 26; c++) begin
      checks++;
      if (s_log[c] !== exp[c-1] || v_log[c] !== 1'b1) begin
        errors++; $display("FAIL ff_bit c=%0d got s=%b v=%b want s=%b v=1", c, s_log[c], v_log[c], exp[c-1]);
      end
    end
    checks++; if (n_valid != 26) begin errors++; $display("FAIL ff_len got %0d want 26", n_valid); end
    checks++; if (max_ones != 6) begin errors++; $display("FAIL ff_maxones got %0d want 6", max_ones); end
    checks++; if (r_log[17] !== 1'b1) begin errors++; $display("FAIL ff_ready17 got %b want 1", r_log[17]); end
    checks++; if (v_log[27] !== 1'b0) begin errors++; $display("FAIL ff_vfall got %b want 0", v_log[27]); end
  endtask

  task automatic test_stuff_last();
    logic [0:16] exp = 17'b00000001_00111111_0;
    int nr = 0;
    bq[0] = 8'hFC;
    run_pkt(1, 1'b1, 1, -1, 26);
    for (int c = 1; c <= 17; c++) begin
      checks++;
      if (s_log[c] !== exp[c-1] || v_log[c] !== 1'b1) begin
        errors++; $display("FAIL fc_bit c=%0d got s=%b v=%b want s=%b v=1", c, s_log[c], v_log[c], exp[c-1]);
      end
    end
    for (int c = 9; c < 26; c++) if (r_log[c]) nr++;
    checks++; if (nr != 0) begin errors++; $display("FAIL fc_ready_after got %0d want 0", nr); end
    checks++; if (n_valid != 17) begin errors++; $display("FAIL fc_len got %0d want 17", n_valid); end
    checks++; if (v_log[18] !== 1'b0) begin errors++; $display("FAIL fc_vfall got %b want 0", v_log[18]); end
    checks++; if (b_log[19] !== 1'b1 || b_log[20] !== 1'b0) begin errors++; $display("FAIL fc_busy b19=%b b20=%b want 1/0", b_log[19], b_log[20]); end
  endtask

  task automatic test_underrun();
    logic [0:15] exp = 16'b00000001_10100101;
    int nu = 0;
    bq[0] = 8'hA5; bq[1] = 8'h00;
    run_pkt(2, 1'b1, 1, -1, 26);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (s_log[c] !== exp[c-1] || v_log[c] !== 1'b1) begin
        errors++; $display("FAIL ur_bit c=%0d got s=%b v=%b want s=%b v=1", c, s_log[c], v_log[c], exp[c-1]);
      end
    end
    for (int c = 0; c < 26; c++) if (u_log[c]) nu++;
    checks++; if (r_log[16] !== 1'b1) begin errors++; $display("FAIL ur_ready16 got %b want 1", r_log[16]); end
    checks++; if (u_log[17] !== 1'b1 || nu != 1) begin errors++; $display("FAIL ur_pulse u17=%b count=%0d want 1/1", u_log[17], nu); end
    checks++; if (v_log[17] !== 1'b1 || v_log[18] !== 1'b0) begin errors++; $display("FAIL ur_vfall v17=%b v18=%b want 1/0", v_log[17], v_log[18]); end
    checks++; if (b_log[19] !== 1'b1 || b_log[20] !== 1'b0) begin errors++; $display("FAIL ur_busy b19=%b b20=%b want 1/0", b_log[19], b_log[20]); end
  endtask

  task automatic test_mid_reset();
    logic [0:15] exp = 16'b00000001_01001011;
    bq[0] = 8'hD2;
    run_pkt(1, 1'b1, 1, -1, 12);
    checks++; if (v_log[11] !== 1'b1) begin errors++; $display("FAIL mr_active got %b want 1", v_log[11]); end
    reset_l = 1'b0;
    #1;
    checks++;
    if ({bus.tx_serial_data, bus.tx_data_valid, bus.tx_busy, bus.tx_underrun, bus.tx_byte_ready} !== 5'b0) begin
      errors++; $display("FAIL mr_outs got %b want 00000", {bus.tx_serial_data, bus.tx_data_valid, bus.tx_busy, bus.tx_underrun, bus.tx_byte_ready});
    end
    @(posedge gclk); #1;
    reset_l = 1'b1;
    @(posedge gclk); #1;
    run_pkt(1, 1'b1, 1, -1, 24);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (s_log[c] !== exp[c-1] || v_log[c] !== 1'b1) begin
        errors++; $display("FAIL mr_bit c=%0d got s=%b v=%b want s=%b v=1", c, s_log[c], v_log[c], exp[c-1]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [0:15] exp = 16'b00000001_01001011;
    int nv = 0;
    bq[0] = 8'hD2;
    run_pkt(1, 1'b1, 1, 5, 28);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (s_log[c] !== exp[c-1] || v_log[c] !== 1'b1) begin
        errors++; $display("FAIL si_bit c=%0d got s=%b v=%b want s=%b v=1", c, s_log[c], v_log[c], exp[c-1]);
      end
    end
    for (int c = 17; c < 28; c++) if (v_log[c]) nv++;
    checks++; if (nv != 0) begin errors++; $display("FAIL si_extra got %0d valid cycles want 0", nv); end
    checks++; if (b_log[19] !== 1'b0) begin errors++; $display("FAIL si_busy got %b want 0", b_log[19]); end
  endtask

  initial begin
    reset_l           = 1'b0;
    bus.tx_start      = 1'b0;
    bus.tx_byte       = 8'h00;
    bus.tx_byte_valid = 1'b0;
    bus.tx_last       = 1'b0;
    test_reset();
    test_single();
    test_stuff_ff();
    test_stuff_last();
    test_underrun();
    test_mid_reset();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
